sdram_port_arb: RTL and testbench

Time-multiplexes the single byte-wide CPU/chipset port of the SDRAM controller between three requesters: Z80 CPU, FDC DMA and ROM/snapshot loader. Generates the `clkref` slot reference so the controller's 8-cycle access slot is phase-locked to the arbiter. Converts each requester's level request into the controller's edge-triggered `oe`/`we` pulse, and returns read data with a one-cycle acknowledge. It sits between the core's bus logic and the SDRAM controller; the vram and tape ports are outside its scope.

---
 rtl/sdram_arb_pkg.sv | 24 ++
 rtl/sdram_port_arb_if.sv | 43 ++++
 rtl/sdram_port_arb_rr_pick2.sv | 23 ++
 rtl/sdram_port_arb.sv | 130 +++++++++++++
 tb/tb_sdram_port_arb.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM CPU-port arbiter.
// Requester indices, FSM encoding and slot length.
package sdram_arb_pkg;

    localparam int REQ_CPU  = 0;
    localparam int REQ_FDC  = 1;
    localparam int REQ_LD   = 2;
    localparam int SLOT_LEN = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACTIVE,
        ST_DONE
    } arb_state_t;

    typedef struct packed {
        logic        wr;
        logic [22:0] addr;
        logic [1:0]  bank;
        logic [7:0]  din;
    } req_t;

endpackage

// File: rtl/sdram_port_arb_if.sv
// Requester and controller side signals of the SDRAM port arbiter.
// master: bus logic plus controller; slave: the arbiter.
interface sdram_port_arb_if;

    logic        cpu_req, fdc_req, ld_req;
    logic        cpu_wr, fdc_wr, ld_wr;
    logic [22:0] cpu_addr, fdc_addr, ld_addr;
    logic [1:0]  cpu_bank, fdc_bank, ld_bank;
    logic [7:0]  cpu_din, fdc_din, ld_din;
    logic        cpu_ack, fdc_ack, ld_ack;
    logic [7:0]  rdata;
    logic        clkref;
    logic        oe, we;
    logic [22:0] addr;
    logic [1:0]  bank;
    logic [7:0]  din;
    logic [7:0]  dout;

    modport master (
        output cpu_req, fdc_req, ld_req,
        output cpu_wr, fdc_wr, ld_wr,
        output cpu_addr, fdc_addr, ld_addr,
        output cpu_bank, fdc_bank, ld_bank,
        output cpu_din, fdc_din, ld_din,
        output dout,
        input  cpu_ack, fdc_ack, ld_ack,
        input  rdata, clkref, oe, we,
        input  addr, bank, din
    );

    modport slave (
        input  cpu_req, fdc_req, ld_req,
        input  cpu_wr, fdc_wr, ld_wr,
        input  cpu_addr, fdc_addr, ld_addr,
        input  cpu_bank, fdc_bank, ld_bank,
        input  cpu_din, fdc_din, ld_din,
        input  dout,
        output cpu_ack, fdc_ack, ld_ack,
        output rdata, clkref, oe, we,
        output addr, bank, din
    );

endinterface

// File: rtl/sdram_port_arb_rr_pick2.sv
// Round-robin choice between FDC and loader; owns the rr bit.
// rr flips on every FDC/loader grant, whichever of the two won.
module rr_pick2 (
    input  logic clk,
    input  logic reset,
    input  logic fdc_req,
    input  logic ld_req,
    input  logic adv,
    output logic pick_ld
);

    logic rr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rr <= 1'b0;
        else if (adv)
            rr <= ~rr;
    end

    always_comb pick_ld = ld_req & (~fdc_req | rr);

endmodule

// File: rtl/sdram_port_arb.sv
// Three-way arbiter for the SDRAM controller's byte-wide CPU port.
// Issues one oe/we strobe per slot and returns data with a 1-cycle ack.
module sdram_port_arb
    import sdram_arb_pkg::*;
#(
    parameter int ISSUE_PH    = 7,
    parameter int CAPTURE_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    sdram_port_arb_if.slave  bus
);

    localparam int LCW = $clog2(CAPTURE_LAT);
    localparam logic [LCW-1:0] LC_LAST = LCW'(CAPTURE_LAT - 1);
    localparam logic [2:0]     PH_ISS  = 3'(ISSUE_PH);

    arb_state_t     state;
    logic [2:0]     ph;
    logic [2:0]     ph_nxt;
    logic [LCW-1:0] lc;
    logic [1:0]     win;
    logic           wr_q;
    logic [2:0]     ack;

    req_t       r_cpu, r_fdc, r_ld, g;
    logic [1:0] sel;
    logic       any_req, pick_ld, issue, adv;

    assign r_cpu = '{bus.cpu_wr, bus.cpu_addr, bus.cpu_bank, bus.cpu_din};
    assign r_fdc = '{bus.fdc_wr, bus.fdc_addr, bus.fdc_bank, bus.fdc_din};
    assign r_ld  = '{bus.ld_wr, bus.ld_addr, bus.ld_bank, bus.ld_din};

    assign any_req = bus.cpu_req | bus.fdc_req | bus.ld_req;
    assign issue   = (state == ST_WAIT) && (ph == PH_ISS);
    assign adv     = issue && !bus.cpu_req && any_req;
    assign ph_nxt  = ph + 3'd1;

    rr_pick2 u_rr (
        .clk     (clk),
        .reset   (reset),
        .fdc_req (bus.fdc_req),
        .ld_req  (bus.ld_req),
        .adv     (adv),
        .pick_ld (pick_ld)
    );

    // CPU beats everyone; otherwise the round-robin pick decides.
    always_comb begin
        sel = 2'(REQ_FDC);
        g   = r_fdc;
        if (bus.cpu_req) begin
            sel = 2'(REQ_CPU);
            g   = r_cpu;
        end else if (pick_ld) begin
            sel = 2'(REQ_LD);
            g   = r_ld;
        end
    end

    // clkref is computed from the next phase so it lines up with ph.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ph         <= 3'd0;
            bus.clkref <= 1'b0;
        end else begin
            ph         <= ph_nxt;
            bus.clkref <= ~ph_nxt[2];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            lc        <= '0;
            win       <= 2'd0;
            wr_q      <= 1'b0;
            ack       <= 3'b000;
            bus.oe    <= 1'b0;
            bus.we    <= 1'b0;
            bus.rdata <= 8'hFF;
            bus.addr  <= 23'd0;
            bus.bank  <= 2'd0;
            bus.din   <= 8'd0;
        end else begin
            ack <= 3'b000;
            unique case (state)
                ST_IDLE: begin
                    if (any_req)
                        state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (ph == PH_ISS) begin
                        if (any_req) begin
                            win      <= sel;
                            wr_q     <= g.wr;
                            bus.addr <= g.addr;
                            bus.bank <= g.bank;
                            bus.din  <= g.din;
                            bus.oe   <= ~g.wr;
                            bus.we   <= g.wr;
                            lc       <= '0;
                            state    <= ST_ACTIVE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_ACTIVE: begin
                    lc <= lc + 1'b1;
                    if (lc == LC_LAST) begin
                        if (!wr_q)
                            bus.rdata <= bus.dout;
                        bus.oe <= 1'b0;
                        bus.we <= 1'b0;
                        ack    <= 3'b001 << win;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cpu_ack = ack[REQ_CPU];
    assign bus.fdc_ack = ack[REQ_FDC];
    assign bus.ld_ack  = ack[REQ_LD];

endmodule

// File: tb/tb_sdram_port_arb.sv
// Bench for sdram_port_arb: directed scenarios plus random request mixes
// checked against a priority/round-robin model and a byte memory.
module tb_sdram_port_arb;

    localparam int ISSUE_PH = 7;
    localparam int LAT      = 10;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    sdram_port_arb_if bus();

    sdram_port_arb #(
        .ISSUE_PH    (ISSUE_PH),
        .CAPTURE_LAT (LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    function automatic void chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endfunction

    // Controller stand-in: byte memory, combinational read, write on we.
    logic [7:0]  mem_ctl [0:4095];
    logic        mem_init = 1'b0;
    logic        pl_en    = 1'b0;
    logic [11:0] pl_addr  = '0;
    logic [7:0]  pl_data  = '0;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++)
                mem_ctl[i] <= 8'(i) ^ 8'h5A;
        end else if (pl_en) begin
            mem_ctl[pl_addr] <= pl_data;
        end else if (bus.we) begin
            mem_ctl[bus.addr[11:0]] <= bus.din;
        end
    end

    assign bus.dout = mem_ctl[bus.addr[11:0]];

    // Expected slot phase.
    logic [2:0] bph;
    always @(posedge clk or posedge reset) begin
        if (reset) bph <= 3'd0;
        else       bph <= bph + 3'd1;
    end

    logic [2:0] acks;
    assign acks = {bus.ld_ack, bus.fdc_ack, bus.cpu_ack};

    bit   mon_on   = 1'b0;
    logic prev_ack = 1'b0;

    always @(negedge clk) begin
        if (!reset && mon_on) begin
            chk("ack_onehot", 32'($onehot0(acks)), 32'd1);
            if (prev_ack)
                chk("ack_back2back", 32'(|acks), 32'd0);
            chk("clkref", 32'(bus.clkref), 32'(bph < 3'd4));
        end
        prev_ack <= |acks;
    end

    // Reference model state.
    logic [7:0]  mem_ref [0:4095];
    bit          rr_m;
    logic [7:0]  last_rd;
    bit          rq   [3];
    bit          r_wr [3];
    logic [22:0] r_addr [3];
    logic [1:0]  r_bank [3];
    logic [7:0]  r_din  [3];

    function automatic int model_pick();
        int w;
        if (rq[0]) return 0;
        if (rq[1] && rq[2]) w = rr_m ? 2 : 1;
        else if (rq[1])     w = 1;
        else if (rq[2])     w = 2;
        else                return -1;
        rr_m = !rr_m;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i);
        case (i)
            0: begin
                bus.cpu_req = rq[0];  bus.cpu_wr = r_wr[0];
                bus.cpu_addr = r_addr[0]; bus.cpu_bank = r_bank[0];
                bus.cpu_din = r_din[0];
            end
            1: begin
                bus.fdc_req = rq[1];  bus.fdc_wr = r_wr[1];
                bus.fdc_addr = r_addr[1]; bus.fdc_bank = r_bank[1];
                bus.fdc_din = r_din[1];
            end
            default: begin
                bus.ld_req = rq[2];  bus.ld_wr = r_wr[2];
                bus.ld_addr = r_addr[2]; bus.ld_bank = r_bank[2];
                bus.ld_din = r_din[2];
            end
        endcase
    endtask

    task automatic scramble(input int i);
        case (i)
            0: begin
                bus.cpu_addr = 23'($urandom); bus.cpu_bank = 2'($urandom);
                bus.cpu_din = 8'($urandom);   bus.cpu_wr = 1'($urandom);
            end
            1: begin
                bus.fdc_addr = 23'($urandom); bus.fdc_bank = 2'($urandom);
                bus.fdc_din = 8'($urandom);   bus.fdc_wr = 1'($urandom);
            end
            default: begin
                bus.ld_addr = 23'($urandom); bus.ld_bank = 2'($urandom);
                bus.ld_din = 8'($urandom);   bus.ld_wr = 1'($urandom);
            end
        endcase
    endtask

    task automatic set_req(input int i, input bit wr, input logic [22:0] a,
                           input logic [1:0] b, input logic [7:0] d);
        rq[i] = 1'b1; r_wr[i] = wr; r_addr[i] = a;
        r_bank[i] = b; r_din[i] = d;
        drive(i);
    endtask

    task automatic drop(input int i);
        rq[i] = 1'b0;
        drive(i);
    endtask

    // Wait for one complete access and check it against the model.
    task automatic expect_access(input int w, input bit mutate);
        int who = -1;
        int oe_n = 0;
        int we_n = 0;
        int rph = -1;
        bit seen = 1'b0;
        logic [22:0] sa = '0;
        logic [1:0]  sb = '0;
        logic [7:0]  sd = '0;
        for (int i = 0; i < 48 && who < 0; i++) begin
            tick();
            if (!seen && (bus.oe || bus.we)) begin
                seen = 1'b1;
                sa = bus.addr; sb = bus.bank; sd = bus.din;
                rph = int'(bph);
                if (mutate && w >= 0) scramble(w);
            end
            if (bus.oe) oe_n++;
            if (bus.we) we_n++;
            if (bus.cpu_ack)      who = 0;
            else if (bus.fdc_ack) who = 1;
            else if (bus.ld_ack)  who = 2;
        end
        chk("winner", 32'(who), 32'(w));
        if (w < 0) return;
        chk("issue_phase", 32'(rph), 32'((ISSUE_PH + 1) % 8));
        chk("oe_width", 32'(oe_n), r_wr[w] ? 32'd0 : 32'(LAT));
        chk("we_width", 32'(we_n), r_wr[w] ? 32'(LAT) : 32'd0);
        chk("strobe_addr", 32'(sa), 32'(r_addr[w]));
        chk("strobe_bank", 32'(sb), 32'(r_bank[w]));
        chk("strobe_din", 32'(sd), 32'(r_din[w]));
        chk("addr_held", 32'(bus.addr), 32'(r_addr[w]));
        if (r_wr[w]) mem_ref[r_addr[w][11:0]] = r_din[w];
        else         last_rd = mem_ref[r_addr[w][11:0]];
        chk("rdata", 32'(bus.rdata), 32'(last_rd));
    endtask

    task automatic quiet(input int n, input string tag);
        int strobes = 0;
        int acked = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.oe || bus.we) strobes++;
            if (|acks) acked++;
        end
        chk({tag, "_strobes"}, 32'(strobes), 32'd0);
        chk({tag, "_acks"}, 32'(acked), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_oe"}, 32'(bus.oe), 32'd0);
        chk({tag, "_we"}, 32'(bus.we), 32'd0);
        chk({tag, "_acks"}, 32'(acks), 32'd0);
        chk({tag, "_rdata"}, 32'(bus.rdata), 32'hFF);
        chk({tag, "_addr"}, 32'(bus.addr), 32'd0);
        chk({tag, "_bank"}, 32'(bus.bank), 32'd0);
        chk({tag, "_din"}, 32'(bus.din), 32'd0);
        chk({tag, "_clkref"}, 32'(bus.clkref), 32'd0);
    endtask

    task automatic restart();
        mon_on = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        rr_m = 1'b0;
        last_rd = 8'hFF;
        tick();
        mon_on = 1'b1;
    endtask

    initial begin
        int w;
        int n;
        for (int i = 0; i < 4096; i++) mem_ref[i] = 8'(i) ^ 8'h5A;
        for (int i = 0; i < 3; i++) begin
            rq[i] = 1'b0; r_wr[i] = 1'b0; r_addr[i] = '0;
            r_bank[i] = '0; r_din[i] = '0;
            drive(i);
        end
        rr_m = 1'b0;
        last_rd = 8'hFF;

        // Reset state.
        mem_init = 1'b1;
        tick();
        mem_init = 1'b0;
        tick();
        check_reset_values("reset");
        reset = 1'b0;
        tick();
        mon_on = 1'b1;

        // Single CPU read of 0x000123 holding 0xA5.
        pl_en = 1'b1; pl_addr = 12'h123; pl_data = 8'hA5;
        tick();
        pl_en = 1'b0;
        mem_ref[12'h123] = 8'hA5;
        set_req(0, 1'b0, 23'h000123, 2'd1, 8'h00);
        expect_access(model_pick(), 1'b0);
        drop(0);

        // FDC write then loader read of the same byte.
        set_req(1, 1'b1, 23'h010000, 2'd2, 8'h3C);
        expect_access(model_pick(), 1'b0);
        drop(1);
        set_req(2, 1'b0, 23'h010000, 2'd2, 8'h00);
        expect_access(model_pick(), 1'b0);
        drop(2);

        // All three held: CPU chains, then FDC/loader alternate.
        set_req(0, 1'b0, 23'h000200, 2'd0, 8'h00);
        set_req(1, 1'b1, 23'h000300, 2'd1, 8'h11);
        set_req(2, 1'b0, 23'h000300, 2'd3, 8'h00);
        repeat (3) expect_access(model_pick(), 1'b0);
        drop(0);
        repeat (4) expect_access(model_pick(), 1'b0);
        drop(1);
        drop(2);

        // Reset in the middle of an access, at lc=4.
        set_req(0, 1'b0, 23'h000040, 2'd0, 8'h00);
        n = 0;
        while (!bus.oe && n < 30) begin
            tick();
            n++;
        end
        chk("midrst_oe_rise", 32'(bus.oe), 32'd1);
        repeat (4) tick();
        mon_on = 1'b0;
        reset = 1'b1;
        #1;
        check_reset_values("midrst");
        drop(0);
        tick();
        tick();
        reset = 1'b0;
        rr_m = 1'b0;
        last_rd = 8'hFF;
        tick();
        mon_on = 1'b1;
        quiet(24, "midrst_after");
        set_req(2, 1'b0, 23'h0000AB, 2'd3, 8'h00);
        expect_access(model_pick(), 1'b0);
        drop(2);

        // FDC and loader contend for six accesses from reset.
        restart();
        set_req(1, 1'b0, 23'h000500, 2'd1, 8'h00);
        set_req(2, 1'b1, 23'h000600, 2'd2, 8'h77);
        repeat (6) expect_access(model_pick(), 1'b0);
        drop(1);
        drop(2);

        // Request withdrawn before the issue phase.
        n = 0;
        while (bph != 3'd1 && n < 16) begin
            tick();
            n++;
        end
        set_req(1, 1'b1, 23'h000700, 2'd0, 8'hEE);
        repeat (3) tick();
        drop(1);
        quiet(20, "dropped");
        set_req(0, 1'b0, 23'h000700, 2'd0, 8'h00);
        expect_access(model_pick(), 1'b0);
        drop(0);

        // Random request mixes; fields scrambled after grant.
        repeat (25) begin
            n = $urandom_range(1, 7);
            for (int i = 0; i < 3; i++)
                if (n[i])
                    set_req(i, 1'($urandom_range(0, 1)),
                            23'h000800 + 23'($urandom_range(0, 15)),
                            2'($urandom), 8'($urandom));
            while (rq[0] || rq[1] || rq[2]) begin
                w = model_pick();
                expect_access(w, 1'b1);
                drop(w);
            end
        end

        repeat (4) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
